vector_collect: RTL and testbench

Stream-to-vector gatherer: accepts one BITS-wide floating-point element per cycle on a valid/ready stream and assembles N consecutive elements into a vector `vout[N]`, presented with `out_valid`/`out_ready`. Sits directly upstream of the vector reduction path: it is the writer that feeds `vin[N]`/`in_valid` of the summation blocks from serial sources such as memory readers and FIFOs. It is format-agnostic, so HALF and SINGLE both work; lanes are moved, never interpreted.

---
 rtl/vector_collect_if.sv | 24 ++
 rtl/vector_collect.sv | 102 ++++++++++
 tb/tb_vector_collect.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_collect_if.sv
// Element-in / vector-out stream bundle for vector_collect.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface vector_collect_if #(
  parameter int BITS = 16,
  parameter int N    = 3
);
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_last;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] vout [N];

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, vout
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, vout
  );
endinterface

// File: rtl/vector_collect.sv
// Gathers N consecutive BITS-wide elements into one vector behind a one-deep output register.
// Optional early completion with zero padding on in_last: define VECTOR_COLLECT_PAD_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// valid never depends on ready, and data is held stable while valid && !ready.
module vector_collect #(
  parameter int BITS = 16,
  parameter int N    = 3
) (
  input  logic            clk,
  input  logic            rst,
  vector_collect_if.slave bus,
  output logic            o_dbg_state
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [BITS-1:0] r_cbuf [N];
  logic [BITS-1:0] r_vout [N];
  logic            r_out_valid;

  logic            w_accept;
  logic            w_slot_free;
  logic            w_early;
  logic            w_complete;
  logic [BITS-1:0] w_merged [N];

  assign bus.in_ready  = (r_state == S_FILL);
  assign bus.out_valid = r_out_valid;
  assign bus.vout      = r_vout;
  assign o_dbg_state   = (r_state == S_HOLD);

  assign w_accept    = bus.in_valid && (r_state == S_FILL);
  assign w_slot_free = !r_out_valid || bus.out_ready;

`ifdef VECTOR_COLLECT_PAD_EN
  assign w_early = bus.in_last;
`else
  logic w_unused_last;
  assign w_unused_last = bus.in_last;
  assign w_early       = 1'b0;
`endif

  assign w_complete = w_accept && ((r_idx == LAST_IDX) || w_early);

  // Buffer contents after this accept; lanes past an early-completing element read as +0.0.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_merged[k] = r_cbuf[k];
      if (IW'(k) == r_idx) begin
        w_merged[k] = bus.in_data;
      end else if (w_early && (IW'(k) > r_idx)) begin
        w_merged[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_cbuf[k] <= '0;
        r_vout[k] <= '0;
      end
    end else begin
      case (r_state)
        S_FILL: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            r_cbuf <= w_merged;
            r_idx  <= w_complete ? '0 : r_idx + IW'(1);
            if (w_complete) begin
              if (w_slot_free) begin
                r_vout      <= w_merged;
                r_out_valid <= 1'b1;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          // A held vector implies out_valid is 1, so the slot frees only on handshake.
          if (w_slot_free) begin
            r_vout      <= r_cbuf;
            r_out_valid <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_collect.sv
// Self-checking bench for vector_collect (N=3/BITS=16 plus an N=1/BITS=32 instance).
// Builds with or without VECTOR_COLLECT_PAD_EN; expectations follow the macro.
module tb_vector_collect;
  localparam int BITS = 16;
  localparam int N    = 3;
  localparam int VW   = BITS * N;
`ifdef VECTOR_COLLECT_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct {
    logic            v;
    logic [BITS-1:0] d;
    logic            last;
    logic            ordy;
    logic            exp_ir;
    logic            exp_ov;
  } row_t;

  logic clk;
  logic rst;
  logic dbg_state;
  logic dbg_state1;
  int   n_cmp;
  int   n_err;

  logic [VW-1:0]   exp_q [$];
  logic [BITS-1:0] part [N];
  int              pidx;
  row_t            tbl [$];

  vector_collect_if #(.BITS(BITS), .N(N)) vif ();
  vector_collect_if #(.BITS(32),   .N(1)) vif1 ();

  vector_collect #(.BITS(BITS), .N(N)) dut (
    .clk(clk), .rst(rst), .bus(vif), .o_dbg_state(dbg_state)
  );

  vector_collect #(.BITS(32), .N(1)) dut1 (
    .clk(clk), .rst(rst), .bus(vif1), .o_dbg_state(dbg_state1)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_vout();
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) r[k*BITS +: BITS] = vif.vout[k];
    return r;
  endfunction

  // Scoreboard: the model gathers accepted elements and pushes finished vectors;
  // every output handshake pops and compares.
  always @(negedge clk) begin
    if (rst) begin
      pidx = 0;
      exp_q.delete();
    end else begin
      if (vif.out_valid && vif.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vector", 64'(pack_vout()), 64'hDEAD);
        end else begin
          check("vector", 64'(pack_vout()), 64'(exp_q.pop_front()));
        end
      end
      if (vif.in_valid && vif.in_ready) begin
        part[pidx] = vif.in_data;
        if (pidx == N - 1 || (PAD && vif.in_last)) begin
          logic [VW-1:0] vec;
          vec = '0;
          for (int k = 0; k <= pidx; k++) vec[k*BITS +: BITS] = part[k];
          exp_q.push_back(vec);
          pidx = 0;
        end else begin
          pidx++;
        end
      end
    end
  end

  task automatic add_row(input logic v, input logic [BITS-1:0] d, input logic last,
                         input logic ordy, input logic ir, input logic ov);
    row_t r;
    r.v = v; r.d = d; r.last = last; r.ordy = ordy; r.exp_ir = ir; r.exp_ov = ov;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [BITS-1:0] d, input logic last, input logic ordy);
    @(posedge clk);
    #1;
    vif.in_valid  = v;
    vif.in_data   = d;
    vif.in_last   = last;
    vif.out_ready = ordy;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 64'(vif.out_valid), 64'd0);
    check({tag, "_vout"},      64'(pack_vout()),   64'd0);
    check({tag, "_in_ready"},  64'(vif.in_ready),  64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pidx  = 0;
    rst   = 1'b1;
    vif.in_valid = 1'b0; vif.in_data = '0; vif.in_last = 1'b0; vif.out_ready = 1'b0;
    vif1.in_valid = 1'b0; vif1.in_data = '0; vif1.in_last = 1'b0; vif1.out_ready = 1'b0;

    // Basic collection, vector held exactly one cycle
    add_row(1, 16'h3C00, 0, 1, 1, 0);
    add_row(1, 16'h4000, 0, 1, 1, 0);
    add_row(1, 16'h4200, 0, 1, 1, 0);
    add_row(0, 16'h0000, 0, 1, 1, 1);
    add_row(0, 16'h0000, 0, 1, 1, 0);
    // Streaming 9 elements: out_valid pulses every 3rd cycle, no bubbles
    for (int j = 0; j < 9; j++) add_row(1, 16'h1000 + 16'(j), 0, 1, 1, (j == 3 || j == 6));
    add_row(0, 16'h0000, 0, 1, 1, 1);
    add_row(0, 16'h0000, 0, 1, 1, 0);
    // Back-pressure: 6 elements fill vout + cbuf, 7th stalls, single-cycle release
    for (int j = 0; j < 6; j++) add_row(1, 16'h5000 + 16'(j), 0, 0, 1, (j >= 3));
    add_row(1, 16'h5006, 0, 0, 0, 1);
    add_row(1, 16'h5006, 0, 0, 0, 1);
    add_row(1, 16'h5006, 0, 1, 0, 1);
    add_row(1, 16'h5006, 0, 0, 1, 1);
    add_row(1, 16'h5007, 0, 0, 1, 1);
    add_row(1, 16'h5008, 0, 0, 1, 1);
    add_row(0, 16'h0000, 0, 1, 0, 1);
    add_row(0, 16'h0000, 0, 1, 1, 1);
    add_row(0, 16'h0000, 0, 1, 1, 0);
    // in_last at lane 0: early completion only when padding is built in
    add_row(1, 16'h3C00, 1, 1, 1, 0);
    add_row(1, 16'h1111, 0, 1, 1, PAD);
    add_row(1, 16'h2222, 0, 1, 1, 0);
    add_row(1, 16'h3333, 0, 1, 1, !PAD);
    add_row(0, 16'h0000, 0, 1, 1, PAD);
    add_row(0, 16'h0000, 0, 1, 1, 0);

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    check("reset_n1_out_valid", 64'(vif1.out_valid), 64'd0);
    check("reset_n1_in_ready",  64'(vif1.in_ready),  64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].ordy);
      @(negedge clk);
      check($sformatf("row%0d_in_ready", i),  64'(vif.in_ready),  64'(tbl[i].exp_ir));
      check($sformatf("row%0d_out_valid", i), 64'(vif.out_valid), 64'(tbl[i].exp_ov));
    end

    // Asynchronous reset mid-operation with a held vector and a partial one
    drive(1, 16'h00A1, 0, 0);
    drive(1, 16'h00A2, 0, 0);
    drive(1, 16'h00A3, 0, 0);
    drive(1, 16'h00A4, 0, 0);
    drive(0, 16'h0000, 0, 0);
    @(negedge clk);
    check("pre_reset_out_valid", 64'(vif.out_valid), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 16'h00B1, 0, 1);
    drive(1, 16'h00B2, 0, 1);
    drive(1, 16'h00B3, 0, 1);
    drive(0, 16'h0000, 0, 1);
    @(negedge clk);
    check("post_reset_out_valid", 64'(vif.out_valid), 64'd1);
    check("post_reset_vout", 64'(pack_vout()), 64'({16'h00B3, 16'h00B2, 16'h00B1}));
    drive(0, 16'h0000, 0, 1);
    @(negedge clk);
    check("post_reset_drop", 64'(vif.out_valid), 64'd0);

    // N=1, BITS=32: every accept is a full vector
    @(posedge clk);
    #1;
    vif1.in_valid = 1'b1; vif1.in_data = 32'h3F800000; vif1.out_ready = 1'b1;
    @(negedge clk);
    check("n1_in_ready", 64'(vif1.in_ready), 64'd1);
    check("n1_out_valid_0", 64'(vif1.out_valid), 64'd0);
    @(posedge clk);
    #1 vif1.in_data = 32'h40000000;
    @(negedge clk);
    check("n1_out_valid_1", 64'(vif1.out_valid), 64'd1);
    check("n1_vout_1", 64'(vif1.vout[0]), 64'h3F800000);
    @(posedge clk);
    #1 vif1.in_valid = 1'b0;
    @(negedge clk);
    check("n1_out_valid_2", 64'(vif1.out_valid), 64'd1);
    check("n1_vout_2", 64'(vif1.vout[0]), 64'h40000000);
    @(posedge clk);
    @(negedge clk);
    check("n1_out_valid_3", 64'(vif1.out_valid), 64'd0);

    @(negedge clk);
    check("drain_expected_queue", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
